// File: rtl/seq_player.sv
// seq_player -- colour-sequence playback engine for a memory game.
//
// On an accepted start the block seeds an 8-bit LFSR and plays `len` steps.
// Each step lights one colour LED for ON_CYCLES cycles, then leaves a dark
// gap of OFF_CYCLES cycles. The LFSR advances one shift between steps, so
// the same seed and length always replay the same colours. After the final
// gap a one-cycle done pulse is issued and the block returns to IDLE.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous, active-high reset
//   start    : begin playback (sampled only in IDLE)
//   abort    : cancel playback, return to IDLE without a done pulse
//   seed     : LFSR seed, latched on accepted start (0 is replaced by 8'h01)
//   seq_len  : number of steps, latched on accepted start, clamped to MAX_LEN
//   led      : one-hot colour, 4'b0000 when dark
//   busy     : high while in ON or OFF
//   done     : one-cycle pulse when playback completes
//   step_idx : index of the step being played, starting at 0

module seq_player #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int MAX_LEN    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  input  logic [4:0] seq_len,
  output logic [3:0] led,
  output logic       busy,
  output logic       done,
  output logic [3:0] step_idx
);

  localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [4:0]       MAX_LEN_C = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       lfsr_q;
  logic [4:0]       len_q;
  logic [3:0]       step_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       led_q;
  logic             busy_q;
  logic             done_q;

  // Next-state helpers used by the sequential block.
  logic [7:0] seed_d;      // seed with the all-zero lock-up state replaced
  logic [4:0] len_d;       // clamped sequence length
  logic [7:0] lfsr_d;      // LFSR after one shift
  logic       last_step;   // current step is the final one

  assign seed_d    = (seed == 8'h00) ? 8'h01 : seed;
  assign len_d     = (seq_len > MAX_LEN_C) ? MAX_LEN_C : seq_len;
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign last_step = (({1'b0, step_q} + 5'd1) == len_q);

  // Single FSM block: state, datapath and outputs all register together so
  // that led/busy/done line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      len_q   <= 5'd0;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      // Abort beats everything else, including a start seen in IDLE.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          led_q  <= 4'b0000;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            lfsr_q <= seed_d;
            len_q  <= len_d;
            step_q <= 4'd0;
            cnt_q  <= '0;
            if (len_d == 5'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ON;
              busy_q  <= 1'b1;
              led_q   <= 4'b0001 << seed_d[1:0];
            end
          end
        end

        S_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_q   <= '0;
            state_q <= S_OFF;
            led_q   <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_OFF: begin
          if (cnt_q == OFF_LAST) begin
            cnt_q <= '0;
            if (last_step) begin
              // LFSR intentionally left as-is after the final step.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ON;
              step_q  <= step_q + 4'd1;
              lfsr_q  <= lfsr_d;
              led_q   <= 4'b0001 << lfsr_d[1:0];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          led_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          led_q   <= 4'b0000;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_seq_player.sv
// Testbench for seq_player (default parameters: ON=4, OFF=2, MAX_LEN=16).
// Expected per-cycle outputs are queued when a playback is started and
// popped one per cycle as the DUT produces them.

module tb_seq_player;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic [4:0] seq_len;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic [3:0] step_idx;

  seq_player dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .seed     (seed),
    .seq_len  (seq_len),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] step;
    logic       chk_step;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic push_exp(input logic [3:0] l, input logic b, input logic d,
                          input logic [3:0] s, input logic cs);
    exp_t e;
    e.led = l; e.busy = b; e.done = d; e.step = s; e.chk_step = cs;
    exp_q.push_back(e);
  endtask

  // Expected trace for a full playback: steps, done pulse, then one IDLE cycle.
  task automatic push_play(input logic [7:0] sd, input int n);
    logic [7:0] l;
    int len;
    l   = (sd == 8'h00) ? 8'h01 : sd;
    len = (n > 16) ? 16 : n;
    for (int s = 0; s < len; s++) begin
      repeat (ON_C)  push_exp(4'b0001 << l[1:0], 1'b1, 1'b0, 4'(s), 1'b1);
      repeat (OFF_C) push_exp(4'b0000, 1'b1, 1'b0, 4'(s), 1'b1);
      if (s != len - 1) l = lfsr_next(l);
    end
    push_exp(4'b0000, 1'b0, 1'b1, 4'd0, 1'b0);
    push_exp(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Pulse start for one cycle; returns sampled just after the accepting edge.
  task automatic drive_start(input logic [7:0] sd, input logic [4:0] n);
    seed = sd; seq_len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; seed = 8'h00; seq_len = 5'd3;
    tick(); tick();
    vectors++;
    if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: got led=%b busy=%b done=%b step=%0d, expected 0000/0/0/0",
               led, busy, done, step_idx);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got led=%b busy=%b done=%b, expected 0000/0/0", led, busy, done);
    end
    $display("test_reset: outputs checked during and after reset");
  endtask

  task automatic test_len1();
    exp_t e;
    int cyc = 0;
    repeat (ON_C)  push_exp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1);
    repeat (OFF_C) push_exp(4'b0000, 1'b1, 1'b0, 4'd0, 1'b1);
    push_exp(4'b0000, 1'b0, 1'b1, 4'd0, 1'b0);
    push_exp(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_start(8'h01, 5'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL len1 cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      cyc++;
      tick();
    end
    $display("test_len1: seed=01 len=1, %0d cycles checked", cyc);
  endtask

  task automatic test_len3();
    exp_t e;
    logic [3:0] colours [3];
    int cyc = 0;
    colours[0] = 4'b0010; colours[1] = 4'b0100; colours[2] = 4'b0001;
    for (int s = 0; s < 3; s++) begin
      repeat (ON_C)  push_exp(colours[s], 1'b1, 1'b0, 4'(s), 1'b1);
      repeat (OFF_C) push_exp(4'b0000, 1'b1, 1'b0, 4'(s), 1'b1);
    end
    push_exp(4'b0000, 1'b0, 1'b1, 4'd0, 1'b0);
    push_exp(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    drive_start(8'h01, 5'd3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL len3 cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      cyc++;
      tick();
    end
    $display("test_len3: seed=01 len=3, %0d cycles checked", cyc);
  endtask

  task automatic test_len0();
    exp_t e;
    int cyc = 0;
    push_play(8'h01, 0);
    drive_start(8'h01, 5'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL len0 cyc%0d: got led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
                 cyc, led, busy, done, e.led, e.busy, e.done);
      end
      cyc++;
      tick();
    end
    $display("test_len0: len=0, %0d cycles checked", cyc);
  endtask

  task automatic test_seed0();
    exp_t e;
    int cyc = 0;
    push_play(8'h01, 5);
    drive_start(8'h00, 5'd5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL seed0 cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      cyc++;
      tick();
    end
    $display("test_seed0: seed=00 len=5 vs seed=01, %0d cycles checked", cyc);
  endtask

  // seq_len=31 clamps to 16; start/seed/seq_len are disturbed mid-playback.
  task automatic test_len31();
    exp_t e;
    int cyc = 0;
    push_play(8'hA5, 31);
    drive_start(8'hA5, 5'd31);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL len31 cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      if (cyc == 20) begin start = 1'b1; seed = 8'hFF; seq_len = 5'd2; end
      if (cyc == 21) start = 1'b0;
      if (cyc == 50) begin start = 1'b1; seed = 8'h00; seq_len = 5'd0; end
      if (cyc == 51) start = 1'b0;
      cyc++;
      tick();
    end
    $display("test_len31: seed=A5 len=31 (16 steps), %0d cycles checked", cyc);
  endtask

  // start held high: ignored while playing, re-accepted on the IDLE cycle.
  task automatic test_back_to_back();
    exp_t e;
    int cyc = 0;
    push_play(8'h5A, 2);
    void'(exp_q.pop_back());  // second playback begins right after the IDLE cycle
    push_exp(4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    push_play(8'h5A, 2);
    seed = 8'h5A; seq_len = 5'd2; start = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      if (cyc == 14) start = 1'b0;
      cyc++;
      tick();
    end
    $display("test_back_to_back: two seed=5A len=2 playbacks, %0d cycles checked", cyc);
  endtask

  task automatic test_abort();
    exp_t e;
    int cyc = 0;
    push_play(8'h37, 4);
    drive_start(8'h37, 5'd4);
    while (cyc <= 10) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL abort_pre cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      if (cyc == 10) abort = 1'b1;  // first OFF cycle of step 1
      cyc++;
      tick();
    end
    abort = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_post cyc%0d: got led=%b busy=%b done=%b, expected 0000/0/0",
                 i, led, busy, done);
      end
      tick();
    end
    cyc = 0;
    push_play(8'h37, 4);
    drive_start(8'h37, 5'd4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL abort_replay cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      cyc++;
      tick();
    end
    $display("test_abort: abort in step-1 OFF then replay, %0d replay cycles checked", cyc);
  endtask

  task automatic test_abort_start();
    seed = 8'h01; seq_len = 5'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_start cyc%0d: got led=%b busy=%b done=%b, expected 0000/0/0",
                 i, led, busy, done);
      end
      tick();
    end
    $display("test_abort_start: start with abort in IDLE not accepted");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc = 0;
    push_play(8'h01, 3);
    drive_start(8'h01, 5'd3);
    while (cyc <= 12) begin
      e = exp_q.pop_front();
      vectors++;
      if (led !== e.led || busy !== e.busy || done !== e.done ||
          (e.chk_step && step_idx !== e.step)) begin
        miscompares++;
        $display("FAIL reset_mid_pre cyc%0d: got led=%b busy=%b done=%b step=%0d, expected led=%b busy=%b done=%b step=%0d",
                 cyc, led, busy, done, step_idx, e.led, e.busy, e.done, e.step);
      end
      if (cyc == 12) begin reset = 1'b1; start = 1'b1; end  // ON of step 2
      cyc++;
      tick();
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_mid_post cyc%0d: got led=%b busy=%b done=%b step=%0d, expected 0000/0/0/0",
                 i, led, busy, done, step_idx);
      end
      if (i == 1) begin reset = 1'b0; start = 1'b0; end
      tick();
    end
    $display("test_reset_mid: reset during step-2 ON, start with reset ignored");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; seed = 8'h00; seq_len = 5'd0;
    test_reset();
    test_len1();
    test_len3();
    test_len0();
    test_seed0();
    test_len31();
    test_back_to_back();
    test_abort();
    test_abort_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter ON_CYCLES, default 4: number of cycles each colour LED is lit per step.
REQ-002 Parameter OFF_CYCLES, default 2: number of dark gap cycles after each step.
REQ-003 Parameter MAX_LEN, default 16: maximum sequence length.
REQ-004 Port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-006 Port start, input, 1 bit: level/pulse from the game init/round flag; sampled only in IDLE.
REQ-007 Port abort, input, 1 bit: cancels playback.
REQ-008 Port seed, input, 8 bits: LFSR seed, latched on accepted start.
REQ-009 Port seq_len, input, 5 bits: number of steps to play, latched on accepted start.
REQ-010 Port led, output, 4 bits: one-hot colour display, 4'b0000 when dark.
REQ-011 Port busy, output, 1 bit: high in the ON and OFF states.
REQ-012 Port done, output, 1 bit: one-cycle pulse when playback completes.
REQ-013 Port step_idx, output, 4 bits: index of the current step, starting at 0.

Function
REQ-014 The FSM SHALL have four states: IDLE, ON, OFF and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch seed into the 8-bit lfsr, substituting 8'h01 if seed=0.
REQ-016 On the same accepted start, it SHALL latch len = min(seq_len, MAX_LEN) and set step_idx=0.
REQ-017 After an accepted start, the next state SHALL be DONE if len=0, otherwise ON.
REQ-018 In ON, led SHALL equal 4'b0001 << lfsr[1:0], starting in the first cycle after start is accepted.
REQ-019 ON SHALL last exactly ON_CYCLES cycles, counted by an internal counter, and then go to OFF.
REQ-020 In OFF, led SHALL be 0, and the state SHALL last exactly OFF_CYCLES cycles.
REQ-021 On the last OFF cycle, if step_idx+1 = len, the next state SHALL be DONE.
REQ-022 Otherwise, on the last OFF cycle: step_idx increments, lfsr advances one shift, and the next state is ON.
REQ-023 The LFSR shift SHALL be lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-024 The LFSR SHALL be left unchanged when leaving the final step.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, led SHALL be 0, and the next state SHALL be IDLE.
REQ-026 A playback of len=N SHALL take N*(ON_CYCLES+OFF_CYCLES) cycles in ON/OFF, followed by a 1-cycle done pulse.
REQ-027 start SHALL be ignored in ON, OFF and DONE; seed and seq_len changes during playback SHALL have no effect.
REQ-028 When abort=1 in any state, the next state SHALL be IDLE with led=0, busy=0, done=0, and no done pulse.
REQ-029 When start and abort are both 1 in IDLE, abort SHALL win and start is not accepted.
REQ-030 The same seed and len SHALL always replay an identical colour sequence.
REQ-031 busy SHALL equal (state==ON || state==OFF), registered together with the state.

Reset
REQ-032 When reset=1, at the next edge: state=IDLE, led=0, busy=0, done=0, step_idx=0, lfsr=8'h01, counters=0.
REQ-033 reset SHALL override start and abort, including in the middle of playback.

Verification
REQ-034 Seed 8'h01, seq_len=1, start for 1 cycle -> led=0010 for 4 cycles, then 0 for 2 cycles, then done=1 for 1 cycle, then IDLE.
REQ-035 Seed 8'h01, seq_len=3 -> led sequence 0010, 0100, 0001 (lfsr 01, 02, 04), with step_idx 0, 1, 2; busy high for 18 cycles; one done pulse.
REQ-036 seq_len=0 -> no led activity, busy stays 0, done pulse on the 2nd cycle after start; seq_len=31 -> exactly 16 steps played.
REQ-037 Seed 8'h00 -> same output as seed 8'h01; start pulsed mid-playback -> no restart, and timing is unchanged.
REQ-038 abort during OFF of step 1 -> led=0 and busy=0 on the next cycle, no done pulse; a new start then replays from step 0.
REQ-039 reset asserted during ON of step 2 -> all outputs at reset values on the next cycle; start together with reset -> not accepted.
